// File: rtl/dnn_accel_bank_arbiter.sv
// Two-master Avalon-MM arbiter in front of one single-port RAM bank.
// Round-robin with a bounded m0 burst allowance; reads return one cycle after issue.
module dnn_accel_bank_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int M0_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [3:0] BURST_LIM = 4'(M0_BURST);

  logic       last_grant;
  logic [3:0] burst_cnt;
  logic       rdv0;
  logic       rdv1;

  logic req0;
  logic req1;
  logic m0_first;
  logic grant0;
  logic grant1;

  // Grant is decided from requests and registered state only, so waitrequest never
  // depends on anything coming back from the RAM.
  always_comb begin
    req0     = m0_read | m0_write;
    req1     = m1_read | m1_write;
    m0_first = last_grant | (burst_cnt < BURST_LIM);
    grant0   = ~reset & req0 & (~req1 | m0_first);
    grant1   = ~reset & req1 & ~(req0 & m0_first);
  end

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    ram_write      = 1'b0;
    ram_chipselect = grant0 | grant1;
    if (grant1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      ram_write      = m1_write;
    end else if (grant0) begin
      ram_write      = m0_write;
    end
  end

  assign ram_clken = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      burst_cnt  <= 4'd0;
      rdv0       <= 1'b0;
      rdv1       <= 1'b0;
    end else begin
      // read+write together counts as a write, so it never produces a read response
      rdv0 <= grant0 & m0_read & ~m0_write;
      rdv1 <= grant1 & m1_read & ~m1_write;
      if (grant0) begin
        last_grant <= 1'b0;
        burst_cnt  <= (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
      end else if (grant1) begin
        last_grant <= 1'b1;
        burst_cnt  <= 4'd0;
      end else begin
        burst_cnt  <= 4'd0;
      end
    end
  end

  assign m0_readdatavalid = rdv0 & ~reset;
  assign m1_readdatavalid = rdv1 & ~reset;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_dnn_accel_bank_arbiter.sv
// Bench for dnn_accel_bank_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of arbitration and bank contents.
module tb_dnn_accel_bank_arbiter;
  localparam int M0_BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;

  int vectors = 0;
  int miscompares = 0;

  dnn_accel_bank_arbiter #(.ADDR_W(10), .DATA_W(32), .M0_BURST(M0_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // The bank itself: single port, registered read, byte-lane writes, preloaded with 0.
  logic [31:0] bank [1024] = '{default: '0};
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) bank[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= bank[ram_address];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [1024] = '{default: '0};
  bit          mdl_prev_m1;
  int          mdl_streak;
  bit          pend0, pend1;
  logic [31:0] pdat0, pdat1;

  // Values observed in the most recent tick
  logic        obs_wait0, obs_wait1, obs_rdv0, obs_rdv1;
  logic [31:0] obs_rd0, obs_rd1;
  int          obs_grant;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One bus cycle: inputs already driven; sample and check mid-cycle, then advance the model.
  task automatic tick();
    bit q0, q1, g0, g1;
    q0 = m0_read | m0_write;
    q1 = m1_read | m1_write;
    g0 = 0; g1 = 0;
    if (!reset) begin
      if (q0 && !q1) g0 = 1;
      else if (q1 && !q0) g1 = 1;
      else if (q0 && q1) begin
        if (mdl_prev_m1 || mdl_streak < M0_BURST) g0 = 1; else g1 = 1;
      end
    end
    #2;
    obs_wait0 = m0_waitrequest; obs_wait1 = m1_waitrequest;
    obs_rdv0 = m0_readdatavalid; obs_rdv1 = m1_readdatavalid;
    obs_rd0 = m0_readdata; obs_rd1 = m1_readdata;
    obs_grant = (q0 && !m0_waitrequest && !reset) ? 0 :
                (q1 && !m1_waitrequest && !reset) ? 1 : 2;
    chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, reset | (q0 & ~g0)});
    chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, reset | (q1 & ~g1)});
    chk("ram_chipselect", {31'd0, ram_chipselect}, {31'd0, g0 | g1});
    chk("ram_write", {31'd0, ram_write}, {31'd0, (g0 & m0_write) | (g1 & m1_write)});
    chk("ram_address", {22'd0, ram_address}, {22'd0, g1 ? m1_address : m0_address});
    chk("m0_readdatavalid", {31'd0, m0_readdatavalid}, {31'd0, ~reset & pend0});
    chk("m1_readdatavalid", {31'd0, m1_readdatavalid}, {31'd0, ~reset & pend1});
    if (!reset && pend0) chk("m0_readdata", m0_readdata, pdat0);
    if (!reset && pend1) chk("m1_readdata", m1_readdata, pdat1);
    @(posedge clk);
    if (reset) begin
      mdl_prev_m1 = 1; mdl_streak = 0; pend0 = 0; pend1 = 0;
    end else begin
      pend0 = g0 && m0_read && !m0_write;
      pend1 = g1 && m1_read && !m1_write;
      if (pend0) pdat0 = ref_mem[m0_address];
      if (pend1) pdat1 = ref_mem[m1_address];
      if (g0 && m0_write) ref_mem[m0_address] = merge(ref_mem[m0_address], m0_writedata, m0_byteenable);
      if (g1 && m1_write) ref_mem[m1_address] = merge(ref_mem[m1_address], m1_writedata, m1_byteenable);
      if (g0) begin
        mdl_prev_m1 = 0; mdl_streak = (mdl_streak < 15) ? mdl_streak + 1 : 15;
      end else if (g1) begin
        mdl_prev_m1 = 1; mdl_streak = 0;
      end else begin
        mdl_streak = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    reset = 1; idle();
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    mdl_prev_m1 = 1; mdl_streak = 0; pend0 = 0; pend1 = 0; pdat0 = '0; pdat1 = '0;
    @(negedge clk);

    // Reset with both masters reading, then release: m0 first, then burst pattern.
    m0_read = 1; m1_read = 1; m0_address = 10'd10; m1_address = 10'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_rdv0", {31'd0, obs_rdv0}, 32'd0);
    end
    chk("ram_clken", {31'd0, ram_clken}, 32'd1);
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      m0_address = 10'(k); m1_address = 10'(100 + k);
      tick();
      chk("grant_pattern", obs_grant, (k % (M0_BURST + 1) == M0_BURST) ? 1 : 0);
      if (k == 0) chk("first_m1_wait", {31'd0, obs_wait1}, 32'd1);
      if (k == 1) chk("first_rdv0", {31'd0, obs_rdv0}, 32'd1);
    end
    idle(); tick();

    // Partial write then read-back of the top word.
    m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
    tick();
    idle(); m0_read = 1; m0_address = 10'h3FF;
    tick();
    idle(); tick();
    chk("partial_write_rd", obs_rd0, 32'h0000BEEF);
    chk("partial_write_rdv", {31'd0, obs_rdv0}, 32'd1);

    // Preload 0..7, then eight back-to-back m0 reads.
    for (int i = 0; i < 8; i++) begin
      idle(); m1_write = 1; m1_address = 10'(i); m1_byteenable = 4'hF;
      m1_writedata = 32'hA5000000 | 32'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin m0_read = 1; m0_address = 10'(i); end else m0_read = 0;
      tick();
      if (i < 8) chk("burst_wait0", {31'd0, obs_wait0}, 32'd0);
      if (i > 0) begin
        chk("burst_rdv0", {31'd0, obs_rdv0}, 32'd1);
        chk("burst_data", obs_rd0, 32'hA5000000 | 32'(i - 1));
      end
    end

    // m1 read granted, reset next cycle: response dropped, m0 priority restored.
    idle(); m1_read = 1; m1_address = 10'd3;
    tick();
    idle(); reset = 1;
    tick();
    chk("reset_drop_rdv1", {31'd0, obs_rdv1}, 32'd0);
    tick();
    chk("reset_drop_rdv1_b", {31'd0, obs_rdv1}, 32'd0);
    reset = 0; m0_read = 1; m1_read = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_reset_pattern", obs_grant, (k % (M0_BURST + 1) == M0_BURST) ? 1 : 0);
    end
    idle(); tick();

    // read+write together is a write.
    m0_read = 1; m0_write = 1; m0_address = 10'd5; m0_byteenable = 4'hF;
    m0_writedata = 32'h12345678;
    tick();
    idle(); tick();
    chk("rw_no_rdv", {31'd0, obs_rdv0}, 32'd0);
    m0_read = 1; m0_address = 10'd5;
    tick();
    idle(); tick();
    chk("rw_readback", obs_rd0, 32'h12345678);

    // Random traffic over a small address window so read-after-write hits are frequent.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      m0_read = 1'($urandom); m0_write = 1'($urandom_range(0, 3) == 0);
      m1_read = 1'($urandom); m1_write = 1'($urandom_range(0, 3) == 0);
      m0_address = 10'($urandom_range(0, 15)); m1_address = 10'($urandom_range(0, 15));
      m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
      m0_writedata = $urandom; m1_writedata = $urandom;
      tick();
    end
    reset = 0; idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
